uart_cmd_decoder: RTL
=====================

// Module: uart_cmd_decoder
// PURPOSE
//   Sits directly downstream of the UART receiver and consumes its byte stream (level byte-ready flag + 8-bit data).
//   Frames bytes into commands: 1 opcode byte + optional 4-byte little-endian argument.
//   Updates trigger configuration registers (delay, pulse width) and issues arm/disarm strobes to the trigger generator.
//   Reports malformed, timed-out or rejected commands on a one-cycle error strobe.
// PARAMETERS
//   TIMEOUT_CYCLES  270000  inter-byte timeout in clk cycles (10 ms @ 27 MHz); 0 disables timeout
//   DEFAULT_WIDTH   27      reset value of pulse_width (1 us @ 27 MHz)
// PORTS
//   clk          in   1   system clock (27 MHz)
//   rst          in   1   asynchronous, active-high reset
//   rx_ready     in   1   UART byte-ready level; rises once per received byte, stays high until next start bit
//   rx_data      in   8   received byte, stable while rx_ready high
//   trig_busy    in   1   trigger generator armed or firing
//   delay_cycles out  32  trigger delay in clk cycles
//   pulse_width  out  32  trigger pulse width in clk cycles
//   arm          out  1   one-cycle arm strobe
//   disarm       out  1   one-cycle disarm strobe
//   cmd_error    out  1   one-cycle error strobe
// BEHAVIOUR
//   Reset values: delay_cycles=0, pulse_width=DEFAULT_WIDTH, arm=disarm=cmd_error=0, state IDLE, rx_ready_q=1.
//   - rx_ready_q resets to 1 so a high rx_ready at reset release is not treated as a new byte.
//   Byte strobe: byte_stb = rx_ready & ~rx_ready_q (registered copy). Exactly one strobe per byte; level otherwise ignored.
//   Opcodes: 'D'(0x44) set delay, arg; 'W'(0x57) set width, arg; 'A'(0x41) arm, no arg; 'C'(0x43) disarm, no arg.
//   FSM:
//   - IDLE, byte_stb:
//     - 'D'/'W': latch opcode, clear arg_cnt -> ARG.
//     - 'A'/'C': -> EXEC.
//     - Other: cmd_error=1 next cycle, stay IDLE.
//   - ARG, byte_stb: arg <= {rx_data, arg[31:8]}, arg_cnt++; on 4th byte -> CHK if CMD_CHECKSUM_EN, else EXEC.
//   - EXEC (one cycle), then -> IDLE:
//     - 'D'/'W': write target register; if trig_busy, do not write and pulse cmd_error instead.
//     - 'A': arm=1.
//     - 'C': disarm=1; always accepted.
//   - Latency: final byte strobe at cycle N -> register update/strobe visible at N+2 (edge reg + EXEC).
//   Timeout: counter clears on every byte_stb and in IDLE; increments otherwise.
//   - Reaching TIMEOUT_CYCLES outside IDLE -> IDLE, partial arg discarded, cmd_error pulse.
//   - byte_stb in the same cycle as expiry wins: byte accepted, no error.
//   Registers hold values indefinitely; arg width 32 bits, no saturation; 0 is a legal value for both registers.
//   Async rst mid-command: FSM->IDLE, partial arg discarded, registers restored to reset values.
//   Strobes are mutually exclusive per cycle.
// CONFIGURATION
//   `CMD_CHECKSUM_EN defined:
//   - 'D'/'W' frames carry a 6th byte = XOR of opcode and the 4 arg bytes; 'A'/'C' carry a 2nd byte = opcode XOR.
//   - Mismatch -> cmd_error, no register write or strobe.
//   - CHK state waits for that byte under the same timeout.
//   Undefined: no checksum byte, no CHK state; frames are 5 bytes ('D'/'W') or 1 byte ('A'/'C').
// STRUCTURE
//   Package uart_cmd_pkg:
//   - Opcode localparams OP_DELAY/OP_WIDTH/OP_ARM/OP_DISARM.
//   - FSM state encodings ST_IDLE/ST_ARG/ST_CHK/ST_EXEC.
//   - ARG_BYTES=4.
//   Sub-module cmd_timeout_counter: clear/enable in, expired out, parameter TIMEOUT_CYCLES.
//   Edge detect, arg shifter and FSM stay in this module.
// TESTING
//   1. Bytes 44 10 27 00 00 (trig_busy=0) -> delay_cycles=0x00002710 two cycles after last byte strobe; no cmd_error.
//   2. Byte 41 -> single arm pulse; byte 43 -> single disarm pulse; rx_ready held high 1000 cycles -> no second pulse.
//   3. Byte 5A -> cmd_error one cycle, registers unchanged; next frame 57 64 00 00 00 -> pulse_width=100.
//   4. Bytes 44 01 02, then silence TIMEOUT_CYCLES -> cmd_error, delay_cycles unchanged.
//      Then 44 01 00 00 00 -> delay_cycles=1 (parser resynced).
//   5. trig_busy=1, frame 57 05 00 00 00 -> cmd_error, pulse_width stays 27; 43 under trig_busy -> disarm pulse.
//   6. rst asserted mid-frame after 44 AA -> all outputs at reset values immediately.
//      With CMD_CHECKSUM_EN: 44 01 00 00 00 44 -> error; 44 01 00 00 00 45 -> delay_cycles=1.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Purpose  : Shared opcodes, FSM state encodings and framing constants for
//            the UART command decoder and its helpers.
// Revision : 1.0  initial release
// ============================================================================
package uart_cmd_pkg;

  // Command opcodes (ASCII)
  localparam logic [7:0] OP_DELAY  = 8'h44;  // 'D' set trigger delay
  localparam logic [7:0] OP_WIDTH  = 8'h57;  // 'W' set trigger pulse width
  localparam logic [7:0] OP_ARM    = 8'h41;  // 'A' arm
  localparam logic [7:0] OP_DISARM = 8'h43;  // 'C' disarm

  // Decoder FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARG  = 2'd1;
  localparam logic [1:0] ST_CHK  = 2'd2;
  localparam logic [1:0] ST_EXEC = 2'd3;

  // Argument framing: little-endian, fixed length
  localparam int ARG_BYTES = 4;
  localparam int ARG_W     = ARG_BYTES * 8;
  localparam int ARG_CNT_W = $clog2(ARG_BYTES);

  // Opcodes that are followed by an argument
  function automatic logic opHasArg(input logic [7:0] op);
    return (op == OP_DELAY) || (op == OP_WIDTH);
  endfunction

  // Any opcode the decoder understands
  function automatic logic opIsValid(input logic [7:0] op);
    return opHasArg(op) || (op == OP_ARM) || (op == OP_DISARM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : cmd_timeout_counter
// Purpose  : Inter-byte timeout for the command decoder. Counts enabled
//            cycles since the last clear and flags expiry once the count
//            reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables the timer.
// Ports    : clk     in  1  system clock
//            rst     in  1  asynchronous active-high reset
//            clear   in  1  restart the count (byte received / parser idle)
//            enable  in  1  count this cycle (parser waiting mid-frame)
//            expired out 1  count has reached TIMEOUT_CYCLES while enabled
// Revision : 1.0  initial release
// ============================================================================
module cmd_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst, clear, enable};
      assign expired  = 1'b0;
    end else begin : g_enabled
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYCLES);

      logic [CNT_W-1:0] r_count;

      // Saturates at the limit so expiry stays asserted until the parser
      // reacts and clears the counter.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_count <= '0;
        end else if (clear) begin
          r_count <= '0;
        end else if (enable && (r_count != C_LIMIT)) begin
          r_count <= r_count + 1'b1;
        end
      end

      assign expired = enable && (r_count == C_LIMIT);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decoder
// Purpose  : Frames the UART receiver byte stream into commands (opcode plus
//            optional 4-byte little-endian argument), updates the trigger
//            delay / pulse-width registers and issues arm / disarm strobes.
//            Malformed, timed-out or rejected commands raise a one-cycle
//            cmd_error strobe.
// Config   : `CMD_CHECKSUM_EN - every frame carries a trailing XOR checksum
//            byte checked in the CHK state. Undefined: no checksum byte.
// Ports    : clk          in   1  system clock (27 MHz)
//            rst          in   1  asynchronous active-high reset
//            rx_ready     in   1  UART byte-ready level
//            rx_data      in   8  received byte, stable while rx_ready high
//            trig_busy    in   1  trigger generator armed or firing
//            delay_cycles out 32  trigger delay in clk cycles
//            pulse_width  out 32  trigger pulse width in clk cycles
//            arm          out  1  one-cycle arm strobe
//            disarm       out  1  one-cycle disarm strobe
//            cmd_error    out  1  one-cycle error strobe
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 270000,
  parameter int unsigned DEFAULT_WIDTH  = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  input  logic        trig_busy,
  output logic [31:0] delay_cycles,
  output logic [31:0] pulse_width,
  output logic        arm,
  output logic        disarm,
  output logic        cmd_error
);

  localparam logic [31:0] C_DEFAULT_WIDTH = 32'(DEFAULT_WIDTH);

`ifdef CMD_CHECKSUM_EN
  localparam logic [1:0] C_AFTER_ARG   = ST_CHK;
  localparam logic [1:0] C_AFTER_NOARG = ST_CHK;
`else
  localparam logic [1:0] C_AFTER_ARG   = ST_EXEC;
  localparam logic [1:0] C_AFTER_NOARG = ST_EXEC;
`endif

  logic [1:0]           r_state;
  logic [1:0]           w_nextState;
  logic                 r_rxReadyQ;
  logic                 w_byteStb;
  logic [7:0]           r_opcode;
  logic [ARG_W-1:0]     r_arg;
  logic [ARG_CNT_W-1:0] r_argCnt;
  logic                 w_lastArg;
  logic                 w_expired;
  logic                 w_sumOk;
  logic [31:0]          r_delay;
  logic [31:0]          r_width;
  logic                 r_arm;
  logic                 r_disarm;
  logic                 r_error;

  // Output-logic decisions, registered below so every strobe is glitch-free
  logic                 w_armSet;
  logic                 w_disarmSet;
  logic                 w_errSet;
  logic                 w_wrDelay;
  logic                 w_wrWidth;

  // --------------------------------------------------------------------------
  // Byte strobe: rising edge of the ready level. The registered copy resets
  // high so a level already high at reset release is not taken as a byte.
  // --------------------------------------------------------------------------
  assign w_byteStb = rx_ready & ~r_rxReadyQ;
  assign w_lastArg = (r_argCnt == ARG_CNT_W'(ARG_BYTES - 1));

`ifdef CMD_CHECKSUM_EN
  logic [7:0] r_xor;  // running XOR of opcode and argument bytes
  assign w_sumOk = (rx_data == r_xor);
`else
  assign w_sumOk = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Inter-byte timeout: runs only while waiting for more bytes of a frame
  // --------------------------------------------------------------------------
  cmd_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_byteStb || (r_state == ST_IDLE)),
    .enable ((r_state == ST_ARG) || (r_state == ST_CHK)),
    .expired(w_expired)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state. A byte arriving in the expiry cycle wins over the timeout.
  // --------------------------------------------------------------------------
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_byteStb) begin
          if (opHasArg(rx_data)) begin
            w_nextState = ST_ARG;
          end else if (opIsValid(rx_data)) begin
            w_nextState = C_AFTER_NOARG;
          end
        end
      end
      ST_ARG: begin
        if (w_byteStb) begin
          if (w_lastArg) begin
            w_nextState = C_AFTER_ARG;
          end
        end else if (w_expired) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_CHK: begin
        if (w_byteStb) begin
          w_nextState = w_sumOk ? ST_EXEC : ST_IDLE;
        end else if (w_expired) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_EXEC: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_armSet    = 1'b0;
    w_disarmSet = 1'b0;
    w_errSet    = 1'b0;
    w_wrDelay   = 1'b0;
    w_wrWidth   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_errSet = w_byteStb && !opIsValid(rx_data);
      end
      ST_ARG: begin
        w_errSet = !w_byteStb && w_expired;
      end
      ST_CHK: begin
        w_errSet = w_byteStb ? !w_sumOk : w_expired;
      end
      ST_EXEC: begin
        // Register writes are refused while the trigger generator is busy;
        // disarm is always honoured.
        case (r_opcode)
          OP_DELAY: begin
            w_wrDelay = !trig_busy;
            w_errSet  = trig_busy;
          end
          OP_WIDTH: begin
            w_wrWidth = !trig_busy;
            w_errSet  = trig_busy;
          end
          OP_ARM: begin
            w_armSet = 1'b1;
          end
          OP_DISARM: begin
            w_disarmSet = 1'b1;
          end
          default: begin
            w_errSet = 1'b1;
          end
        endcase
      end
      default: begin
        w_errSet = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: edge detect, opcode latch, argument shifter, config registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxReadyQ <= 1'b1;
      r_opcode   <= 8'h00;
      r_arg      <= '0;
      r_argCnt   <= '0;
      r_delay    <= 32'd0;
      r_width    <= C_DEFAULT_WIDTH;
      r_arm      <= 1'b0;
      r_disarm   <= 1'b0;
      r_error    <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      r_xor      <= 8'h00;
`endif
    end else begin
      r_rxReadyQ <= rx_ready;
      r_arm      <= w_armSet;
      r_disarm   <= w_disarmSet;
      r_error    <= w_errSet;

      if ((r_state == ST_IDLE) && w_byteStb) begin
        r_opcode <= rx_data;
        r_argCnt <= '0;
`ifdef CMD_CHECKSUM_EN
        r_xor    <= rx_data;
`endif
      end

      // Little-endian: each new byte enters at the top and shifts down, so
      // the first argument byte ends up in bits [7:0].
      if ((r_state == ST_ARG) && w_byteStb) begin
        r_arg    <= {rx_data, r_arg[ARG_W-1:8]};
        r_argCnt <= r_argCnt + 1'b1;
`ifdef CMD_CHECKSUM_EN
        r_xor    <= r_xor ^ rx_data;
`endif
      end

      if (w_wrDelay) begin
        r_delay <= r_arg;
      end
      if (w_wrWidth) begin
        r_width <= r_arg;
      end
    end
  end

  assign delay_cycles = r_delay;
  assign pulse_width  = r_width;
  assign arm          = r_arm;
  assign disarm       = r_disarm;
  assign cmd_error    = r_error;

endmodule
`default_nettype wire
